cvxif_mac_unit: RTL and testbench

Custom-instruction coprocessor on the core's CV-X-IF, downstream of the core's issue/commit/result channels. Accepts custom-3 instructions (ADD/MUL/MAC/ACC_RD/ACC_CLR) with their register operands and queues them in order. Holds each one until the core commits or kills it, then executes committed ones one at a time over a fixed latency. Returns results through a valid/ready result channel.

---
 rtl/cvxif_mac_unit.sv | 177 +++++++++++++++++
 tb/tb_cvxif_mac_unit.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cvxif_mac_unit.sv
// CV-X-IF coprocessor: queues custom-3 ADD/MUL/MAC/ACC_RD/ACC_CLR in order,
// holds each until commit/kill, then executes committed ones over a fixed latency.
module cvxif_mac_unit #(
  parameter int XLEN     = 64,
  parameter int ID_WIDTH = 3,
  parameter int DEPTH    = 4,
  parameter int LATENCY  = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                issue_valid_i,
  output logic                issue_ready_o,
  input  logic [31:0]         issue_instr_i,
  input  logic [XLEN-1:0]     issue_rs1_i,
  input  logic [XLEN-1:0]     issue_rs2_i,
  input  logic [ID_WIDTH-1:0] issue_id_i,
  output logic                issue_accept_o,
  output logic                issue_writeback_o,
  input  logic                commit_valid_i,
  input  logic [ID_WIDTH-1:0] commit_id_i,
  input  logic                commit_kill_i,
  output logic                result_valid_o,
  input  logic                result_ready_i,
  output logic [ID_WIDTH-1:0] result_id_o,
  output logic [4:0]          result_rd_o,
  output logic [XLEN-1:0]     result_data_o,
  output logic                result_we_o,
  output logic                busy_o
);
  localparam int NID = 1 << ID_WIDTH;
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = $clog2(LATENCY + 1);

  localparam logic [2:0] OP_ADD = 3'd0, OP_MUL = 3'd1, OP_MAC = 3'd2,
                         OP_RD  = 3'd3, OP_CLR = 3'd4;

  typedef struct packed {
    logic [ID_WIDTH-1:0] id;
    logic [4:0]          rd;
    logic [2:0]          op;
    logic [XLEN-1:0]     rs1;
    logic [XLEN-1:0]     rs2;
  } entry_t;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  entry_t          q [DEPTH];
  entry_t          hd, cur;
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [PW:0]     count;
  logic [NID-1:0]  pend, cmt, kil;
  state_t          state, state_nx;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] acc, mac_val, res_val;
  logic supported, push, pop, hv, c_hit, hd_kill, hd_cmt, launch_ok, launch, clr, c_set, last;
  logic unused_bits;

  assign unused_bits = ^issue_instr_i[24:15];

  assign supported = issue_instr_i[6:0] == 7'h7B && issue_instr_i[31:25] == 7'd0 &&
                     issue_instr_i[14:12] <= OP_CLR;
  assign issue_accept_o    = issue_valid_i && supported;
  assign issue_writeback_o = issue_accept_o && issue_instr_i[14:12] != OP_CLR;
  assign issue_ready_o     = !rst_i && count != (PW+1)'(DEPTH);

  assign push = issue_valid_i && issue_ready_o && supported;
  assign hd   = q[rd_ptr];
  assign hv   = count != '0;

  // Same-cycle commit/kill of the head is folded in so launch is not delayed a cycle
  assign c_hit     = commit_valid_i && commit_id_i == hd.id;
  assign hd_kill   = hv && (kil[hd.id] || (c_hit && commit_kill_i));
  assign hd_cmt    = hv && (cmt[hd.id] || (c_hit && !commit_kill_i));
  assign launch_ok = hd_cmt && !hd_kill && state == IDLE;
  assign pop       = hd_kill || launch_ok;
  assign launch    = launch_ok && hd.op != OP_CLR;
  assign clr       = launch_ok && hd.op == OP_CLR;
  // A commit landing on the entry being popped must not leave a stale flag behind
  assign c_set = commit_valid_i &&
                 ((push && issue_id_i == commit_id_i) ||
                  (pend[commit_id_i] && !(pop && hd.id == commit_id_i)));

  always_ff @(posedge clk_i)
    if (push) q[wr_ptr] <= {issue_id_i, issue_instr_i[11:7], issue_instr_i[14:12], issue_rs1_i, issue_rs2_i};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend <= '0;
      cmt  <= '0;
      kil  <= '0;
    end else begin
      if (pop) begin
        pend[hd.id] <= 1'b0;
        cmt[hd.id]  <= 1'b0;
        kil[hd.id]  <= 1'b0;
      end
      if (push) pend[issue_id_i] <= 1'b1;
      if (c_set) begin
        if (commit_kill_i) kil[commit_id_i] <= 1'b1;
        else               cmt[commit_id_i] <= 1'b1;
      end
    end
  end

  assign last = state == EXEC && cnt == CW'(1);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (launch) state_nx = EXEC;
      EXEC:    if (last) state_nx = DONE;
      DONE:    if (result_ready_i) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign mac_val = acc + cur.rs1 * cur.rs2;

  always_comb begin
    res_val = '0;
    case (cur.op)
      OP_ADD:  res_val = cur.rs1 + cur.rs2;
      OP_MUL:  res_val = cur.rs1 * cur.rs2;
      OP_MAC:  res_val = mac_val;
      OP_RD:   res_val = acc;
      default: res_val = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      cnt           <= '0;
      cur           <= '0;
      acc           <= '0;
      result_id_o   <= '0;
      result_rd_o   <= '0;
      result_data_o <= '0;
    end else begin
      state <= state_nx;
      if (launch) begin
        cur <= hd;
        cnt <= CW'(LATENCY - 1);
      end else if (state == EXEC && !last) begin
        cnt <= cnt - 1'b1;
      end
      if (clr) acc <= '0;
      if (last) begin
        result_id_o   <= cur.id;
        result_rd_o   <= cur.rd;
        result_data_o <= res_val;
        if (cur.op == OP_MAC) acc <= mac_val;
      end
    end
  end

  assign result_valid_o = state == DONE;
  assign result_we_o    = state == DONE;
  assign busy_o         = hv || state != IDLE;

endmodule

// File: tb/tb_cvxif_mac_unit.sv
// Bench for cvxif_mac_unit: decode/op tables, multi-cycle hand sequences and a
// randomized run scored against an in-order transaction model.
module tb_cvxif_mac_unit;
  logic        clk = 0, rst = 1;
  logic        issue_valid = 0, commit_valid = 0, ckill = 0, rready = 0;
  logic [31:0] instr = '0;
  logic [63:0] rs1 = '0, rs2 = '0;
  logic [2:0]  iid = '0, cid = '0;
  logic        issue_ready, accept, wb, rvalid, rwe, busy;
  logic [2:0]  rid;
  logic [4:0]  rrd;
  logic [63:0] rdata;
  int n_chk = 0, n_fail = 0;

  cvxif_mac_unit #(.XLEN(64), .ID_WIDTH(3), .DEPTH(4), .LATENCY(2)) dut (
    .clk_i(clk), .rst_i(rst),
    .issue_valid_i(issue_valid), .issue_ready_o(issue_ready), .issue_instr_i(instr),
    .issue_rs1_i(rs1), .issue_rs2_i(rs2), .issue_id_i(iid),
    .issue_accept_o(accept), .issue_writeback_o(wb),
    .commit_valid_i(commit_valid), .commit_id_i(cid), .commit_kill_i(ckill),
    .result_valid_o(rvalid), .result_ready_i(rready), .result_id_o(rid),
    .result_rd_o(rrd), .result_data_o(rdata), .result_we_o(rwe), .busy_o(busy));

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] rd);
    return {7'h00, 10'h000, f3, rd, 7'h7B};
  endfunction

  typedef struct { logic [31:0] w; logic v; logic acc; logic wb; } dec_t;
  typedef struct { logic [2:0] f3; logic [2:0] id; logic [4:0] rd; logic [63:0] a, b; logic has; logic [63:0] exp; } op_t;

  // Directed op: issue at t, commit at t+1, result expected exactly at t+3
  task automatic do_op(input op_t o);
    string nm;
    nm = $sformatf("op_f%0d_id%0d", o.f3, o.id);
    instr = mk(o.f3, o.rd); rs1 = o.a; rs2 = o.b; iid = o.id; issue_valid = 1;
    step();
    issue_valid = 0; commit_valid = 1; cid = o.id; ckill = 0;
    step();
    commit_valid = 0;
    chk({nm, "_early_valid"}, rvalid, 0);
    if (!o.has) chk({nm, "_clr_busy"}, busy, 0);
    step();
    chk({nm, "_valid"}, rvalid, o.has);
    if (o.has) begin
      chk({nm, "_id"}, rid, o.id);
      chk({nm, "_rd"}, rrd, o.rd);
      chk({nm, "_data"}, rdata, o.exp);
      chk({nm, "_we"}, rwe, 1);
      rready = 1; step(); rready = 0;
      chk({nm, "_drop_valid"}, rvalid, 0);
      chk({nm, "_idle"}, busy, 0);
    end
  endtask

  // ---- behavioural model for the randomized run ----
  typedef struct { logic [2:0] id; logic [4:0] rd; logic [2:0] op; logic [63:0] a, b; bit res, kil; } ent_t;
  typedef struct { logic [2:0] id; logic [4:0] rd; logic [63:0] data; } exp_t;
  ent_t ent[$];
  exp_t expq[$];
  logic [2:0] popped[$];
  bit inuse[8];
  logic [63:0] macc = '0;
  bit pv = 0, ptaken = 0;
  logic [63:0] pdata;
  logic [2:0] pid;
  logic [4:0] prd;

  task automatic model_drain();
    ent_t e;
    logic [127:0] p;
    while (ent.size() > 0 && ent[0].res) begin
      e = ent.pop_front();
      popped.push_back(e.id);
      if (e.kil) continue;
      p = e.a * e.b;
      case (e.op)
        3'd0: expq.push_back('{e.id, e.rd, e.a + e.b});
        3'd1: expq.push_back('{e.id, e.rd, p[63:0]});
        3'd2: begin macc = macc + p[63:0]; expq.push_back('{e.id, e.rd, macc}); end
        3'd3: expq.push_back('{e.id, e.rd, macc});
        default: macc = '0;
      endcase
    end
  endtask

  task automatic rand_cycle(input bit drain);
    logic [2:0] f3, nid, j;
    logic [4:0] rd;
    bit bad, ok, fire;
    int r, k;
    int idx[$];
    exp_t e;
    if (!busy) begin
      chk("idle_model_empty", ent.size(), 0);
      while (popped.size() > 0) inuse[popped.pop_front()] = 0;
    end
    issue_valid = 0;
    nid = 3'($urandom_range(0, 7));
    if (!drain && $urandom_range(0, 1) == 1) begin
      for (int i = 0; i < 8 && inuse[nid]; i++) nid = nid + 3'd1;
      if (!inuse[nid]) issue_valid = 1;
    end
    if (issue_valid) assert (!inuse[nid]) else $error("duplicate pending id %0d", nid);
    f3 = 3'($urandom_range(0, 5));
    rd = 5'($urandom);
    bad = ($urandom_range(0, 9) == 0);
    instr = mk(f3, rd);
    instr[24:15] = 10'($urandom);
    if (bad) begin
      if ($urandom_range(0, 1) == 1) instr[6:0] = 7'h33;
      else instr[31:25] = 7'h01;
    end
    iid = nid;
    rs1 = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 15)) : {$urandom, $urandom};
    rs2 = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 15)) : {$urandom, $urandom};
    ok = issue_valid && !bad && f3 <= 3'd4;
    fire = ok && issue_ready;

    commit_valid = 0; ckill = 0; cid = '0;
    r = $urandom_range(0, 99);
    if (drain || r < 45) begin
      foreach (ent[i]) if (!ent[i].res) idx.push_back(i);
      if (fire) idx.push_back(-1);
      if (idx.size() > 0) begin
        k = idx[$urandom_range(0, idx.size() - 1)];
        commit_valid = 1;
        cid = (k < 0) ? nid : ent[k].id;
        ckill = !drain && ($urandom_range(0, 3) == 0);
      end
    end else if (r < 50) begin
      j = 3'($urandom_range(0, 7));
      if (!inuse[j] && !(issue_valid && j == nid)) begin
        commit_valid = 1; cid = j; ckill = 1'($urandom_range(0, 1));
      end
    end
    rready = drain || ($urandom_range(0, 9) < 7);
    #1;

    chk("rand_accept", accept, ok);
    chk("rand_writeback", wb, ok && f3 != 3'd4);
    chk("rand_we", rwe, rvalid);
    if (pv && !ptaken) begin
      chk("hold_valid", rvalid, 1);
      chk("hold_id", rid, pid);
      chk("hold_rd", rrd, prd);
      chk("hold_data", rdata, pdata);
    end
    if (rvalid && rready) begin
      if (expq.size() == 0) chk("unexpected_result", rvalid, 0);
      else begin
        e = expq.pop_front();
        chk("rand_id", rid, e.id);
        chk("rand_rd", rrd, e.rd);
        chk("rand_data", rdata, e.data);
        while (popped.size() > 0) begin
          j = popped.pop_front();
          inuse[j] = 0;
          if (j == e.id) break;
        end
      end
    end
    pv = rvalid; ptaken = rvalid && rready; pdata = rdata; pid = rid; prd = rrd;

    if (fire) begin
      ent.push_back('{nid, rd, f3, rs1, rs2, 1'b0, 1'b0});
      inuse[nid] = 1;
    end
    if (commit_valid)
      foreach (ent[i]) if (ent[i].id == cid && !ent[i].res) begin
        ent[i].res = 1; ent[i].kil = ckill;
      end
    model_drain();
    step();
  endtask

  dec_t dec[8];
  op_t  ops[8];

  initial begin
    logic [31:0] w;
    w = mk(3'd0, 5'd1); dec[0] = '{w, 1'b1, 1'b1, 1'b1};
    w = mk(3'd4, 5'd0); dec[1] = '{w, 1'b1, 1'b1, 1'b0};
    w = mk(3'd2, 5'd2); dec[2] = '{w, 1'b1, 1'b1, 1'b1};
    w = mk(3'd5, 5'd3); dec[3] = '{w, 1'b1, 1'b0, 1'b0};
    w = mk(3'd0, 5'd4); w[31:25] = 7'h01; dec[4] = '{w, 1'b1, 1'b0, 1'b0};
    w = mk(3'd0, 5'd5); w[6:0] = 7'h33;   dec[5] = '{w, 1'b1, 1'b0, 1'b0};
    w = mk(3'd1, 5'd6); dec[6] = '{w, 1'b0, 1'b0, 1'b0};
    w = mk(3'd3, 5'd7); dec[7] = '{w, 1'b1, 1'b1, 1'b1};

    ops[0] = '{3'd0, 3'd2, 5'd10, 64'd5, 64'd7, 1'b1, 64'd12};
    ops[1] = '{3'd4, 3'd3, 5'd0,  64'd0, 64'd0, 1'b0, 64'd0};
    ops[2] = '{3'd2, 3'd4, 5'd1,  64'd3, 64'd4, 1'b1, 64'd12};
    ops[3] = '{3'd2, 3'd5, 5'd2,  64'd2, 64'd5, 1'b1, 64'd22};
    ops[4] = '{3'd3, 3'd6, 5'd3,  64'd0, 64'd0, 1'b1, 64'd22};
    ops[5] = '{3'd1, 3'd7, 5'd4,  64'h1_0000_0001, 64'h1_0000_0001, 1'b1, 64'h2_0000_0001};
    ops[6] = '{3'd0, 3'd0, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b1, 64'd1};
    ops[7] = '{3'd1, 3'd1, 5'd5,  64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD};

    // reset values and decode table, applied while held in reset so nothing enqueues
    step(); step();
    chk("rst_ready", issue_ready, 0);
    chk("rst_valid", rvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", rdata, 0);
    chk("rst_id", rid, 0);
    chk("rst_rd", rrd, 0);
    chk("rst_we", rwe, 0);
    foreach (dec[i]) begin
      instr = dec[i].w; issue_valid = dec[i].v; #1;
      chk($sformatf("dec%0d_accept", i), accept, dec[i].acc);
      chk($sformatf("dec%0d_wb", i), wb, dec[i].wb);
    end
    issue_valid = 0; rst = 0;
    step();
    chk("post_rst_ready", issue_ready, 1);
    chk("post_rst_busy", busy, 0);

    foreach (ops[i]) do_op(ops[i]);

    // kill head id1 while id2 is issued; id2 launches right after with no gap
    instr = mk(3'd1, 5'd3); rs1 = 9; rs2 = 9; iid = 1; issue_valid = 1;
    step();
    instr = mk(3'd0, 5'd4); rs1 = 100; rs2 = 23; iid = 2;
    commit_valid = 1; cid = 1; ckill = 1;
    step();
    issue_valid = 0; cid = 2; ckill = 0;
    step();
    commit_valid = 0;
    chk("kill_t3_valid", rvalid, 0);
    chk("kill_t3_busy", busy, 1);
    step();
    chk("kill_valid", rvalid, 1);
    chk("kill_id", rid, 2);
    chk("kill_rd", rrd, 4);
    chk("kill_data", rdata, 123);
    rready = 1; step(); rready = 0;
    chk("kill_done_valid", rvalid, 0);
    chk("kill_done_busy", busy, 0);

    // commit id3 while id0 executes; backpressure id0 for 10 cycles
    instr = mk(3'd0, 5'd6); rs1 = 10; rs2 = 20; iid = 0; issue_valid = 1;
    step();
    instr = mk(3'd1, 5'd7); rs1 = 6; rs2 = 7; iid = 3;
    commit_valid = 1; cid = 0; ckill = 0;
    step();
    issue_valid = 0; cid = 3;
    step();
    commit_valid = 0;
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", rvalid, 1);
      chk("bp_id", rid, 0);
      chk("bp_rd", rrd, 6);
      chk("bp_data", rdata, 30);
      step();
    end
    rready = 1; chk("bp_last_valid", rvalid, 1);
    step(); rready = 0;
    chk("cbh_h1_valid", rvalid, 0);
    chk("cbh_h1_busy", busy, 1);
    step();
    chk("cbh_h2_valid", rvalid, 0);
    step();
    chk("cbh_valid", rvalid, 1);
    chk("cbh_id", rid, 3);
    chk("cbh_rd", rrd, 7);
    chk("cbh_data", rdata, 42);
    rready = 1; step(); rready = 0;
    chk("cbh_idle", busy, 0);

    // fill the queue, then one killed pop reopens it
    for (int i = 0; i < 4; i++) begin
      chk("fill_ready", issue_ready, 1);
      instr = mk(3'd0, 5'(i)); iid = 3'(4 + i); rs1 = 64'(i); rs2 = 1; issue_valid = 1;
      step();
    end
    issue_valid = 0;
    chk("full_ready", issue_ready, 0);
    chk("full_busy", busy, 1);
    commit_valid = 1; cid = 4; ckill = 1;
    step();
    chk("full_pop_ready", issue_ready, 1);
    for (int i = 5; i < 8; i++) begin
      cid = 3'(i); ckill = 1;
      step();
    end
    commit_valid = 0;
    step();
    chk("full_flush_busy", busy, 0);
    chk("full_flush_valid", rvalid, 0);

    // rejected opcode
    instr = mk(3'd0, 5'd1); instr[6:0] = 7'h33; iid = 1; issue_valid = 1; #1;
    chk("rej_accept", accept, 0);
    chk("rej_wb", wb, 0);
    step();
    issue_valid = 0;
    chk("rej_busy", busy, 0);
    step();
    chk("rej_busy2", busy, 0);
    chk("rej_valid", rvalid, 0);

    // reset while a MAC is in EXEC: no result, acc cleared
    instr = mk(3'd2, 5'd9); rs1 = 5; rs2 = 5; iid = 5; issue_valid = 1;
    step();
    issue_valid = 0; commit_valid = 1; cid = 5; ckill = 0;
    step();
    commit_valid = 0;
    chk("mid_busy", busy, 1);
    rst = 1;
    step();
    rst = 0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_data", rdata, 0);
    chk("mid_rst_id", rid, 0);
    chk("mid_rst_we", rwe, 0);
    for (int i = 0; i < 4; i++) begin
      chk("mid_rst_no_result", rvalid, 0);
      step();
    end
    do_op('{3'd3, 3'd6, 5'd12, 64'd0, 64'd0, 1'b1, 64'd0});

    // randomized run against the transaction model (acc is 0 here)
    macc = '0; pv = 0;
    for (int i = 0; i < 3000; i++) rand_cycle(1'b0);
    for (int i = 0; i < 400; i++) begin
      if (ent.size() == 0 && expq.size() == 0 && !busy) break;
      rand_cycle(1'b1);
    end
    chk("drain_done", (ent.size() == 0 && expq.size() == 0 && !busy), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
